// File: rtl/accum_frame_mc_pkg.sv
// Shared defaults and helpers for the frame accumulator and its sibling
// power/threshold stages.
package accum_frame_mc_pkg;

    localparam int DEF_IN_W    = 32;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_SHIFT   = 21;
    localparam int DEF_MIN_OUT = 1;
    localparam int DEF_NUM_CH  = 4;

    // Channel index width: clog2 of the channel count, never below one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accum_scale_sat.sv
// Combinational frame-sum scaler: right shift, clamp to the output maximum,
// then raise anything below the floor up to the floor.
module accum_scale_sat #(
    parameter int ACC_W   = 40,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 21,
    parameter int MIN_OUT = 1
) (
    input  logic [ACC_W-1:0] x,
    output logic [OUT_W-1:0] y
);

    localparam logic [ACC_W-1:0] MAX_V = ACC_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(MIN_OUT);

    logic [ACC_W-1:0] shifted;
    logic [ACC_W-1:0] clamped;

    always_comb begin
        shifted = x >> SHIFT;
        clamped = shifted;
        if (shifted > MAX_V) clamped = MAX_V;
        if (clamped < MIN_V) clamped = MIN_V;
        y = OUT_W'(clamped);
    end

endmodule

// File: rtl/accum_frame_mc.sv
// Multi-channel frame accumulator: saturating per-channel sums closed by
// din_tlast, one scaled result per frame through a single output register.
module accum_frame_mc
    import accum_frame_mc_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int MIN_OUT = DEF_MIN_OUT,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CH_W    = ch_width(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  din,
    input  logic [CH_W-1:0]  din_tchan,
    input  logic             din_tvalid,
    input  logic             din_tlast,
    output logic             din_tready,
    output logic [OUT_W-1:0] dout,
    output logic [CH_W-1:0]  dout_tchan,
    output logic             dout_tvalid,
    output logic             dout_tlast,
    input  logic             dout_tready,
    output logic             err_chan,
    output logic             err_sat
);

    // Handshake: a beat transfers on any cycle where valid && ready are both
    // high; valid never waits on ready, and the output payload is held stable
    // while dout_tvalid is high and dout_tready is low.

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [NUM_CH-1:0] sat;
    logic              accept;
    logic              ch_ok;
    logic              load;
    logic [ACC_W-1:0]  rd_acc;
    logic              rd_sat;
    logic [ACC_W:0]    sum;
    logic              clip;
    logic [ACC_W-1:0]  total;
    logic [OUT_W-1:0]  scaled;

    assign din_tready = !dout_tvalid || dout_tready;
    assign accept     = din_tvalid && din_tready;
    assign ch_ok      = 32'(din_tchan) < NUM_CH;
    assign load       = accept && ch_ok && din_tlast;

    always_comb begin
        rd_acc = '0;
        rd_sat = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(din_tchan) == c) begin
                rd_acc = acc[c];
                rd_sat = sat[c];
            end
        end
    end

    // One extra bit of headroom detects the clip; the last beat is included.
    assign sum   = {1'b0, rd_acc} + (ACC_W+1)'(din);
    assign clip  = sum[ACC_W];
    assign total = clip ? ACC_MAX : sum[ACC_W-1:0];

    accum_scale_sat #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .MIN_OUT(MIN_OUT)
    ) u_scale (
        .x(total),
        .y(scaled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
            sat <= '0;
        end else if (accept && ch_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (32'(din_tchan) == c) begin
                    if (din_tlast) begin
                        acc[c] <= '0;
                        sat[c] <= 1'b0;
                    end else begin
                        acc[c] <= total;
                        sat[c] <= sat[c] | clip;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout        <= OUT_W'(MIN_OUT);
            dout_tchan  <= '0;
            dout_tvalid <= 1'b0;
            dout_tlast  <= 1'b0;
            err_chan    <= 1'b0;
            err_sat     <= 1'b0;
        end else begin
            err_chan <= accept && !ch_ok;
            err_sat  <= load && (rd_sat || clip);
            if (load) begin
                dout        <= scaled;
                dout_tchan  <= din_tchan;
                dout_tvalid <= 1'b1;
                dout_tlast  <= (32'(din_tchan) == NUM_CH - 1);
            end else if (dout_tready) begin
                dout_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accum_frame_mc.sv
// Bench for accum_frame_mc: vector table, directed corner sequences and a
// randomized run against a per-channel sum model.
module tb_accum_frame_mc;

    localparam int CH_W = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     din;
    logic [CH_W-1:0] din_tchan;
    logic            din_tvalid;
    logic            din_tlast;
    logic            din_tready;
    logic [7:0]      dout;
    logic [CH_W-1:0] dout_tchan;
    logic            dout_tvalid;
    logic            dout_tlast;
    logic            dout_tready;
    logic            err_chan;
    logic            err_sat;

    accum_frame_mc #(.NUM_CH(4), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .din(din), .din_tchan(din_tchan), .din_tvalid(din_tvalid),
        .din_tlast(din_tlast), .din_tready(din_tready),
        .dout(dout), .dout_tchan(dout_tchan), .dout_tvalid(dout_tvalid),
        .dout_tlast(dout_tlast), .dout_tready(dout_tready),
        .err_chan(err_chan), .err_sat(err_sat)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_errchan_seen = 0;
    int n_errsat_seen  = 0;
    logic rand_rdy = 1'b0;

    // scoreboard entry: {dout, dout_tchan, dout_tlast}
    logic [11:0] exp_q[$];

    typedef struct {
        logic [2:0]       ch;
        int               nb;
        logic [3:0][31:0] d;
        logic [7:0]       exp_dout;
    } vec_t;
    vec_t vec_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [11:0] mk_exp(input logic [7:0] v, input logic [2:0] ch);
        return {v, ch, ch == 3'd3};
    endfunction

    // driver tasks
    task automatic send(input logic [2:0] ch, input logic [31:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        if (rand_rdy) dout_tready = ($urandom_range(0, 3) != 0);
        din = d; din_tchan = ch; din_tlast = last; din_tvalid = 1'b1;
        #1;
        while (!din_tready) begin
            n++;
            if (n > 100) begin
                n_cmp++; n_fail++;
                $display("FAIL send_timeout: din_tready stuck at 0, required 1");
                break;
            end
            @(negedge clk);
            if (rand_rdy) dout_tready = ($urandom_range(0, 3) != 0);
            #1;
        end
        @(posedge clk);
        #1;
        din_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            dout_tready = 1'b1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic add_vec(input logic [2:0] ch, input int nb, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] d3, input logic [7:0] e);
        vec_t v;
        v.ch = ch; v.nb = nb; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.exp_dout = e;
        vec_q.push_back(v);
    endtask

    // scoreboard monitor: samples well after the falling edge
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (dout_tvalid && dout_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_result: got 0x%0h, required none",
                                 {dout, dout_tchan, dout_tlast});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {dout, dout_tchan, dout_tlast}, e);
                    end
                end
                if (err_chan) n_errchan_seen++;
                if (err_sat)  n_errsat_seen++;
            end
        end
    end

    initial begin
        longint msum [4];
        logic   msat [4];
        int     exp_chan_errs, exp_sat_errs, base_chan, base_sat;

        rst_n = 1'b0; din = '0; din_tchan = '0; din_tvalid = 1'b0; din_tlast = 1'b0;
        dout_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 8'd1);
        check("rst_tchan", dout_tchan, 3'd0);
        check("rst_tvalid", dout_tvalid, 1'b0);
        check("rst_tlast", dout_tlast, 1'b0);
        check("rst_errs", {err_chan, err_sat}, 2'b00);
        check("rst_din_tready", din_tready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // latency: valid exactly one cycle after the accepted tlast beat
        exp_q.push_back(mk_exp(8'd4, 3'd0));
        for (int b = 0; b < 3; b++) send(3'd0, 32'd1 << 21, 1'b0);
        check("lat_no_early_valid", dout_tvalid, 1'b0);
        send(3'd0, 32'd1 << 21, 1'b1);
        check("lat_valid", dout_tvalid, 1'b1);
        check("lat_dout", dout, 8'd4);
        check("lat_no_err_sat", err_sat, 1'b0);
        drain();

        // vector table
        add_vec(3'd0, 4, 32'd1 << 21, 32'd1 << 21, 32'd1 << 21, 32'd1 << 21, 8'd4);
        add_vec(3'd0, 1, 32'd1 << 20, 0, 0, 0, 8'd1);
        add_vec(3'd1, 2, 32'd150 << 21, 32'd150 << 21, 0, 0, 8'd255);
        add_vec(3'd3, 1, 32'd5 << 21, 0, 0, 0, 8'd5);
        add_vec(3'd2, 1, (32'd1 << 21) - 1, 0, 0, 0, 8'd1);
        add_vec(3'd2, 1, 32'd1 << 29, 0, 0, 0, 8'd255);
        add_vec(3'd1, 3, 32'd3 << 21, 32'd1 << 20, 32'd1 << 20, 0, 8'd4);
        add_vec(3'd3, 3, (32'd1 << 21) + (32'd1 << 20), 32'd1 << 20, 32'd7 << 21, 0, 8'd9);
        add_vec(3'd0, 2, 32'd255 << 21, (32'd1 << 21) - 1, 0, 0, 8'd255);
        add_vec(3'd1, 1, 32'd0, 0, 0, 0, 8'd1);
        foreach (vec_q[i]) begin
            exp_q.push_back(mk_exp(vec_q[i].exp_dout, vec_q[i].ch));
            for (int b = 0; b < vec_q[i].nb; b++)
                send(vec_q[i].ch, vec_q[i].d[b], b == vec_q[i].nb - 1);
        end
        drain();

        // accumulator saturation over 257 full-scale beats
        for (int b = 0; b < 256; b++) send(3'd2, 32'hFFFF_FFFF, 1'b0);
        exp_q.push_back(mk_exp(8'd255, 3'd2));
        send(3'd2, 32'hFFFF_FFFF, 1'b1);
        check("sat_err_sat", err_sat, 1'b1);
        check("sat_dout", dout, 8'd255);
        drain();

        // backpressure with a new tlast beat loading on the handshake cycle
        @(negedge clk);
        dout_tready = 1'b0;
        exp_q.push_back(mk_exp(8'd7, 3'd1));
        send(3'd1, 32'd7 << 21, 1'b1);
        @(negedge clk);
        din = 32'd2 << 21; din_tchan = 3'd1; din_tlast = 1'b1; din_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_din_tready_low", din_tready, 1'b0);
            check("bp_held", {dout_tvalid, dout, dout_tchan}, {1'b1, 8'd7, 3'd1});
            @(negedge clk);
        end
        dout_tready = 1'b1;
        exp_q.push_back(mk_exp(8'd2, 3'd1));
        #1;
        check("bp_din_tready_high", din_tready, 1'b1);
        @(posedge clk);
        #1;
        din_tvalid = 1'b0;
        check("bp_reload", {dout_tvalid, dout}, {1'b1, 8'd2});
        drain();

        // interleaved channels, tlast on the third beat of each
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                if (r == 2) exp_q.push_back(mk_exp(8'(3 * (c + 1)), 3'(c)));
                send(3'(c), 32'(c + 1) << 21, r == 2);
            end
        drain();

        // bad channels are dropped and flagged
        send(3'd0, 32'd1 << 21, 1'b0);
        send(3'd5, 32'hFFFF_FFFF, 1'b0);
        check("bad5_err_chan", err_chan, 1'b1);
        send(3'd4, 32'hFFFF_FFFF, 1'b1);
        check("bad4_err_chan", err_chan, 1'b1);
        check("bad4_no_output", dout_tvalid, 1'b0);
        exp_q.push_back(mk_exp(8'd2, 3'd0));
        send(3'd0, 32'd1 << 21, 1'b1);
        check("bad_then_good_no_err", err_chan, 1'b0);
        drain();

        // reset mid-frame discards partial sums and the pending result
        @(negedge clk);
        dout_tready = 1'b0;
        send(3'd2, 32'd10 << 21, 1'b0);
        send(3'd2, 32'd10 << 21, 1'b0);
        send(3'd1, 32'd7 << 21, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {dout, dout_tchan, dout_tvalid, dout_tlast, err_chan, err_sat},
              {8'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        dout_tready = 1'b1;
        exp_q.push_back(mk_exp(8'd3, 3'd2));
        send(3'd2, 32'd3 << 21, 1'b1);
        drain();

        // randomized run against a per-channel sum model
        for (int c = 0; c < 4; c++) begin msum[c] = 0; msat[c] = 1'b0; end
        exp_chan_errs = 0; exp_sat_errs = 0;
        base_chan = n_errchan_seen; base_sat = n_errsat_seen;
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [2:0]  ch;
            logic [31:0] d;
            logic        last;
            longint      s, y;
            r  = $urandom_range(0, 9);
            ch = (r < 8) ? 3'(r % 4) : ((r == 8) ? 3'd4 : 3'd6);
            d  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 1 << 24));
            last = ($urandom_range(0, 3) == 0);
            send(ch, d, last);
            if (ch >= 3'd4) begin
                exp_chan_errs++;
            end else begin
                s = msum[ch] + longint'(d);
                if (s > ((longint'(1) << 40) - 1)) begin
                    s = (longint'(1) << 40) - 1;
                    msat[ch] = 1'b1;
                end
                if (last) begin
                    y = s >> 21;
                    if (y > 255) y = 255;
                    if (y < 1) y = 1;
                    if (msat[ch]) exp_sat_errs++;
                    exp_q.push_back(mk_exp(8'(y), ch));
                    msum[ch] = 0;
                    msat[ch] = 1'b0;
                end else begin
                    msum[ch] = s;
                end
            end
        end
        rand_rdy = 1'b0;
        drain();
        check("rand_err_chan_count", 64'(n_errchan_seen - base_chan), 64'(exp_chan_errs));
        check("rand_err_sat_count", 64'(n_errsat_seen - base_sat), 64'(exp_sat_errs));

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
